// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared constants and types for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  // Instruction handed to decode when the buffer has nothing to offer (MOV r0, r0)
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  // Address of the first fetch after reset unless the top overrides it
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch distance from the head PC that decode expects on PCPlus8
  localparam logic [31:0] PC_AHEAD = 32'd8;

  // One buffered fetch: the instruction word and the address it came from
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buf
// Brief    : Small FIFO holding fetched {instr, pc} entries for decode.
//            Flush wins over push/pop; push with pop keeps the occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head_entry
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // Guard against popping an empty buffer or overflowing a full one
  assign do_pop  = pop & ~is_empty;
  assign do_push = push & (~is_full | do_pop);

  // Wrap a pointer at the buffer depth
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Buffer state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Brief    : Instruction fetch stage. Issues sequential word fetches to
//            instruction memory, buffers returned words in a 2-entry FIFO and
//            presents the head to decode. A writeback redirect flushes the
//            buffer and restarts fetch at the new target.
//            Optional feature macro: IFETCH_PERF_CNT_EN enables the
//            fetch_cnt / bubble_cnt performance counters (tied to zero
//            otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus8,
  output logic        InstrValidF,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     head_entry;
  fetch_entry_t     push_entry;
  logic             instr_valid;
  logic             buf_full;
  logic             pop;
  logic             accept;
  logic [31:0]      redirect_pc;

  assign instr_valid = (buf_count != '0);
  assign buf_full    = (buf_count == CNT_W'(BUF_DEPTH));

  // Decode consumes the head only when it is valid, not stalled and not being flushed
  assign pop = instr_valid & ~stall & ~PCSrcW;

  // Request whenever there is room (or room is being made); never during a
  // redirect or while reset is held, so a stale address is never accepted
  assign imem_req  = ~reset & ~PCSrcW & (~buf_full | pop);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;

  // Word-align the redirect target by masking the byte offset
  assign redirect_pc = ResultW & 32'hFFFF_FFFC;

  assign push_entry.instr = imem_rdata;
  assign push_entry.pc    = pc_q;

  // Fetch PC: redirect wins, otherwise advance by one word per accepted fetch
  always_comb begin
    pc_d = pc_q;
    if (PCSrcW) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (PCSrcW),
    .count      (buf_count),
    .head_entry (head_entry)
  );

  // Decode-facing outputs come only from registered state, never from imem_rdata
  always_comb begin
    InstrValidF = instr_valid;
    if (instr_valid) begin
      InstrF  = head_entry.instr;
      PCPlus8 = head_entry.pc + PC_AHEAD;
    end else begin
      InstrF  = NOP_INSTR;
      PCPlus8 = pc_q + PC_AHEAD;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count accepted fetches and cycles where decode is ready but starved
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + (accept ? 32'd1 : 32'd0);
    bubble_cnt_d = bubble_cnt_q + ((~stall & ~instr_valid) ? 32'd1 : 32'd0);
  end

  // Performance counter registers, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign fetch_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (legal: 2 only).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  in  1  decode not accepting; no pop while high.
REQ-006 SHALL have port PCSrcW  in  1  redirect request, from writeback.
REQ-007 SHALL have port ResultW  in  32  redirect target; bits [1:0] ignored.
REQ-008 SHALL have port imem_req  out  1  fetch request valid.
REQ-009 SHALL have port imem_addr  out  32  fetch word address, held stable while imem_req and not imem_ready.
REQ-010 SHALL have port imem_ready  in  1  request accepted, with data this cycle.
REQ-011 SHALL have port imem_rdata  in  32  instruction word, valid when imem_req and imem_ready.
REQ-012 SHALL have port InstrF  out  32  instruction presented to decode.
REQ-013 SHALL have port PCPlus8  out  32  head-entry PC + 8.
REQ-014 SHALL have port InstrValidF  out  1  buffer head valid.
REQ-015 SHALL have ports fetch_cnt, bubble_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-016 SHALL hold fetch PC pc_q; imem_addr = pc_q.
REQ-017 SHALL drive imem_req = ~PCSrcW and (count < 2 or pop).
REQ-018 SHALL define pop = InstrValidF and ~stall and ~PCSrcW.
REQ-019 SHALL, on accept (imem_req and imem_ready), push {imem_rdata, pc_q} to buffer tail and set pc_q <= pc_q + 4, mod 2^32.
REQ-020 SHALL, with push and pop in the same cycle, keep count unchanged; head advances, new entry at tail.
REQ-021 SHALL never push when count = 2 and no pop; never pop when count = 0.
REQ-022 SHALL drive InstrValidF = (count != 0).
REQ-023 SHALL drive InstrF = head instruction when valid, else NOP_INSTR (32'hE1A0_0000).
REQ-024 SHALL drive PCPlus8 = head PC + 8 when valid, else pc_q + 8.
REQ-025 SHALL, on PCSrcW, clear buffer (count <= 0), set pc_q <= {ResultW[31:2], 2'b00}, and issue no request that cycle.
REQ-026 SHALL give redirect priority over push, pop and stall in the same cycle.
REQ-027 SHALL present the first redirected instruction to decode no earlier than 2 cycles after PCSrcW (1 request cycle + buffer).
REQ-028 SHALL keep all outputs except imem_req free of combinational paths from imem_rdata/imem_ready.

Reset
REQ-029 SHALL, while reset high, force pc_q = RESET_PC, count = 0, head/tail pointers = 0, counters = 0.
REQ-030 SHALL, during reset, output imem_req = 0, InstrValidF = 0, InstrF = NOP_INSTR, PCPlus8 = RESET_PC + 8.
REQ-031 SHALL, on reset deassertion, raise imem_req in the first following cycle with imem_addr = RESET_PC.
REQ-032 SHALL discard a memory handshake in progress when reset asserts mid-request; no push occurs.

Configuration
REQ-033 SHALL compile performance counters only when IFETCH_PERF_CNT_EN is defined.
REQ-034 SHALL, with IFETCH_PERF_CNT_EN defined, increment fetch_cnt per accept and bubble_cnt per cycle with ~stall and ~InstrValidF; both wrap at 2^32.
REQ-035 SHALL, without IFETCH_PERF_CNT_EN, keep both ports and tie them to 32'h0.

Structure
REQ-036 SHALL place NOP_INSTR, the fetch_entry_t typedef {instr[31:0], pc[31:0]} and the RESET_PC default in package ifetch_pkg.
REQ-037 SHALL implement the buffer as sub-module fetch_buf (2-entry FIFO: push, pop, flush, count, head).

Verification
REQ-038 SHALL check reset release with RESET_PC=0 and imem_ready=1: addresses 0,4,8 accepted on consecutive cycles, InstrF follows one cycle after each accept.
REQ-039 SHALL check stall held 5 cycles with ready=1: count saturates at 2, imem_req drops, no entry lost or duplicated, PCs resume in order.
REQ-040 SHALL check PCSrcW=1, ResultW=32'h0000_0103 while count=2: buffer empty next cycle, next imem_addr = 32'h0000_0100, InstrF = NOP until refill.
REQ-041 SHALL check imem_ready low 3 cycles: imem_addr held constant, InstrValidF falls after buffer drains, bubble_cnt += 3 with macro defined.
REQ-042 SHALL check pc_q = 32'hFFFF_FFFC accepted: next imem_addr = 32'h0000_0000, PCPlus8 of that entry = 32'h0000_0004.
REQ-043 SHALL check reset asserted mid-wait (req=1, ready=0): outputs reach reset values immediately; no push appears after release.
